serial_add_seq: RTL and testbench
=================================

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand set present.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports: a, b  input  WIDTH  operands; carryin  input  1  initial carry.
REQ-007 SHALL have port: out_valid  output  1  result present.
REQ-008 SHALL have port: out_ready  input  1  consumer takes result.
REQ-009 SHALL have ports: sum  output  WIDTH  result; carryout  output  1  final carry.
REQ-010 SHALL have port: busy  output  1  high in RUN state.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL assert in_ready only in IDLE and out_valid only in DONE, decoded from state.
REQ-013 SHALL, on an edge with IDLE and in_valid=1, latch a, b and carryin, clear the bit counter and go to RUN.
REQ-014 SHALL, on each RUN edge, add operand LSBs plus the carry register in one full-adder cell, shift both operands right one bit, shift the cell sum into result MSB (result >> 1), and load the cell carry into the carry register.
REQ-015 SHALL enter DONE on the edge processing bit WIDTH-1, so out_valid rises exactly WIDTH edges after the accepting edge.
REQ-016 SHALL hold sum and carryout stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-017 SHALL ignore in_valid outside IDLE; no back-to-back accept in DONE, minimum period WIDTH+2 cycles.
REQ-018 SHALL compute sum = (a+b+carryin) mod 2^WIDTH, carryout = bit WIDTH of the same sum.
REQ-019 SHALL support WIDTH=1 (one RUN cycle); bit counter width clog2(WIDTH+1).

Reset
REQ-020 SHALL, on a reset edge from any state, including mid-RUN, go to IDLE and clear operands, carry, counter, sum and carryout to 0.
REQ-021 SHALL output after reset: in_ready=1, out_valid=0, busy=0, sum=0, carryout=0 (overflow=0 if present).
REQ-022 SHALL give reset priority over in_valid and out_ready on the same edge.

Configuration
REQ-023 SHALL, with SERIAL_ADD_OVERFLOW_EN defined, add output port overflow (1 bit), registered on the final RUN edge as carry-into-MSB XOR carry-out, held through DONE, and cleared by reset.
REQ-024 SHALL, without SERIAL_ADD_OVERFLOW_EN, have no overflow port and no overflow logic; all other behaviour identical.

Structure
REQ-025 SHALL place the state enum typedef and WIDTH default constant in package serial_add_pkg.
REQ-026 SHALL instantiate the team's existing one-bit structural full adder (structuralFullAdder) exactly once as the sole sub-module; no other arithmetic.

Verification (WIDTH=8)
REQ-027 SHALL check: a=0x35, b=0x4A, carryin=0 -> sum=0x7F, carryout=0, out_valid exactly 8 edges after accept.
REQ-028 SHALL check: a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, carryout=0, overflow=1.
REQ-029 SHALL check: a=0xFF, b=0xFF, carryin=1 -> sum=0xFF, carryout=1.
REQ-030 SHALL check: out_ready held 0 for 5 cycles in DONE with in_valid=1 -> sum/carryout stable, in_ready=0, no new operand accepted; after out_ready=1, IDLE next cycle.
REQ-031 SHALL check: reset after 3 RUN edges -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; following op 0x10+0x20 -> 0x30.
REQ-032 SHALL check: WIDTH=1 instance with a=1, b=1, carryin=1 -> sum=1, carryout=1 one edge after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_add_seq_fulladder.sv
// One-bit full adder built from gate-level equations; the only arithmetic in the serial adder.
module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_xor;
    logic ab_and;
    logic prop_and;

    assign ab_xor   = a ^ b;
    assign ab_and   = a & b;
    assign prop_and = ab_xor & cin;
    assign s        = ab_xor ^ cin;
    assign cout     = ab_and | prop_and;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one operand bit per cycle through a single full-adder cell, LSB first.
// Define SERIAL_ADD_OVERFLOW_EN to add a registered signed-overflow output.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             busy
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cell_sum;
    logic             cell_carry;
    logic             last_bit;

    structuralFullAdder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (cell_sum),
        .cout (cell_carry)
    );

    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Each cell sum enters at the MSB so the result is fully aligned after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            result <= '0;
        end else if (state == IDLE && in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= carryin;
            count <= '0;
        end else if (state == RUN) begin
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            result <= WIDTH'({cell_sum, result} >> 1);
            carry  <= cell_carry;
            count  <= count + CW'(1);
        end
    end

    assign sum      = result;
    assign carryout = carry;

`ifdef SERIAL_ADD_OVERFLOW_EN
    // On the MSB cycle the carry register holds the carry into the sign bit.
    always_ff @(posedge clk) begin
        if (reset)                      overflow <= 1'b0;
        else if (state == RUN && last_bit) overflow <= carry ^ cell_carry;
    end
`else
    // Without the overflow option only the unsigned carry-out reports range.
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed corner cases plus random operands
// against an arithmetic reference model; covers WIDTH=8 and WIDTH=1 instances.
module tb_serial_add_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       carryin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carryout;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

`ifdef SERIAL_ADD_OVERFLOW_EN
    logic       ovf;
    logic       ovf1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(8)) dut (
`ifdef SERIAL_ADD_OVERFLOW_EN
        .overflow  (ovf),
`endif
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carryin   (carryin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .busy      (busy)
    );

    serial_add_seq #(.WIDTH(1)) dut1 (
`ifdef SERIAL_ADD_OVERFLOW_EN
        .overflow  (ovf1),
`endif
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .carryin   (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .carryout  (cout1),
        .busy      (busy1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake for one WIDTH=8 operation, checked against plain integer addition.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic vc, input string tag);
        logic [8:0] full;
        int         n;
        full = 9'(va) + 9'(vb) + 9'(vc);
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "/ready_before"}, 32'(in_ready), 32'd1);
        a        = va;
        b        = vb;
        carryin  = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput({tag, "/busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "/ready_run"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "/latency"}, 32'(n), 32'd8);
        checkOutput({tag, "/sum"}, 32'(sum), 32'(full[7:0]));
        checkOutput({tag, "/carryout"}, 32'(carryout), 32'(full[8]));
`ifdef SERIAL_ADD_OVERFLOW_EN
        checkOutput({tag, "/overflow"}, 32'(ovf), 32'((va[7] == vb[7]) && (full[7] != va[7])));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "/valid_after"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "/ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        a          = 8'h5A;
        b          = 8'hA5;
        carryin    = 1'b1;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = 1'b0;
        b1         = 1'b0;
        cin1       = 1'b0;
        tick();
        tick();
        checkOutput("reset/in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        checkOutput("reset/sum", 32'(sum), 32'd0);
        checkOutput("reset/carryout", 32'(carryout), 32'd0);
`ifdef SERIAL_ADD_OVERFLOW_EN
        checkOutput("reset/overflow", 32'(ovf), 32'd0);
`endif
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        applyStimulus(8'h35, 8'h4A, 1'b0, "basic");
        applyStimulus(8'hFF, 8'h01, 1'b0, "wrap");
        applyStimulus(8'h7F, 8'h01, 1'b0, "signed_ovf");
        applyStimulus(8'hFF, 8'hFF, 1'b1, "all_ones");

        // Result must hold in DONE while new operands are offered and not taken.
        a = 8'h12; b = 8'h34; carryin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput("hold/latency", 32'(n), 32'd8);
        a = 8'hAA; b = 8'h55; carryin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold/out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold/in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold/sum", 32'(sum), 32'h47);
            checkOutput("hold/carryout", 32'(carryout), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("hold/idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("hold/idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("hold/idle_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("hold/no_accept", 32'(busy), 32'd0);

        // Abort an operation partway through with reset.
        a = 8'hAB; b = 8'h11; carryin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("midrun/busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrun/in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun/out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun/busy_low", 32'(busy), 32'd0);
        checkOutput("midrun/sum", 32'(sum), 32'd0);
        checkOutput("midrun/carryout", 32'(carryout), 32'd0);
        applyStimulus(8'h10, 8'h20, 1'b0, "after_reset");

        // Single-bit instance finishes one edge after accept.
        checkOutput("w1/in_ready", 32'(in_ready1), 32'd1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        checkOutput("w1/busy", 32'(busy1), 32'd1);
        tick();
        checkOutput("w1/out_valid", 32'(out_valid1), 32'd1);
        checkOutput("w1/sum", 32'(sum1), 32'd1);
        checkOutput("w1/carryout", 32'(cout1), 32'd1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        checkOutput("w1/idle", 32'(in_ready1), 32'd1);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
